// File: rtl/pkt_arb4_pkg.sv
// pkt_arb4 shared constants: port count, pointer width, FSM encoding.
// Imported by pkt_arb4 and pkt_arb4_rr_sel.
package pkt_arb4_pkg;

  localparam int PORT_NUM = 4;
  localparam int PTR_W    = 2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

endpackage

// File: rtl/pkt_arb4_rr_sel.sv
// Round-robin winner select: rotate req so ptr+1 sits at bit 0,
// then take the lowest set bit and map it back to a port index.
module pkt_arb4_rr_sel
  import pkt_arb4_pkg::*;
(
  input  logic [PORT_NUM-1:0] req,
  input  logic [PTR_W-1:0]    ptr,
  output logic [PTR_W-1:0]    win,
  output logic                any
);

  logic [PTR_W-1:0]      base;
  logic [2*PORT_NUM-1:0] dbl;
  logic [PORT_NUM-1:0]   rot;
  logic [PTR_W-1:0]      off;

  // Rotate, priority-encode, and un-rotate the offset.
  always_comb begin
    base = ptr + 2'd1;
    dbl  = {req, req};
    rot  = dbl[base +: PORT_NUM];
    off  = 2'd0;
    priority case (1'b1)
      rot[0]:  off = 2'd0;
      rot[1]:  off = 2'd1;
      rot[2]:  off = 2'd2;
      rot[3]:  off = 2'd3;
      default: off = 2'd0;
    endcase
    win = base + off;
    any = |req;
  end

endmodule

// File: rtl/pkt_arb4.sv
// Four-port packet-granular round-robin arbiter onto one stream bus.
// Define PKT_ARB4_STAT_EN to add per-port accepted-packet counters.
module pkt_arb4
  import pkt_arb4_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int CNT_W  = 32
) (
  input  logic                       clks,
  input  logic                       reset,
  input  logic [PORT_NUM-1:0]        s_vld,
  input  logic [PORT_NUM-1:0]        s_eop,
  input  logic [PORT_NUM*DATA_W-1:0] s_data,
  output logic [PORT_NUM-1:0]        s_rdy,
  output logic                       m_vld,
  output logic                       m_eop,
  output logic [DATA_W-1:0]          m_data,
  output logic [PTR_W-1:0]           m_port,
  input  logic                       m_rdy
`ifdef PKT_ARB4_STAT_EN
  ,
  output logic [PORT_NUM*CNT_W-1:0]  pkt_cnt
`endif
);

  logic [0:0]       state_q, state_d;
  logic [PTR_W-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win;
  logic             any;
  logic             in_xfer;
  logic             done;

  pkt_arb4_rr_sel u_sel (
    .req (s_vld),
    .ptr (ptr_q),
    .win (win),
    .any (any)
  );

  // Combinational output mux from the granted port.
  always_comb begin
    in_xfer = (state_q == XFER);
    m_vld   = in_xfer & s_vld[gnt_q];
    m_eop   = in_xfer & s_eop[gnt_q];
    m_data  = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (gnt_q == PTR_W'(i)) begin
        m_data = s_data[i*DATA_W +: DATA_W];
      end
    end
    s_rdy        = '0;
    s_rdy[gnt_q] = in_xfer & m_rdy;
    done         = m_vld & m_rdy & s_eop[gnt_q];
    m_port       = gnt_q;
  end

  // Next state: grant on any request, release on accepted eop.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          gnt_d   = win;
          state_d = XFER;
        end
      end
      XFER: begin
        if (done) begin
          ptr_d   = gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, grant and last-served pointer; ptr=3 gives port 0 priority.
  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef PKT_ARB4_STAT_EN
  logic [CNT_W-1:0] cnt_q [PORT_NUM];

  // Count accepted eop beats per port; wraps naturally.
  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PORT_NUM; i++) cnt_q[i] <= '0;
    end else if (done) begin
      cnt_q[gnt_q] <= cnt_q[gnt_q] + 1'b1;
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      pkt_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_pkt_arb4.sv
// Scoreboard bench for pkt_arb4: per-port beat queues plus a
// packet-level round-robin reference; directed and random phases.
module tb_pkt_arb4;

  localparam int DW = 64;
  localparam int CW = 32;

  typedef struct packed {
    logic          eop;
    logic [DW-1:0] data;
  } beat_t;

  logic          clks = 1'b0;
  logic          reset;
  logic [3:0]    s_vld, s_eop, s_rdy;
  logic [4*DW-1:0] s_data;
  logic          m_vld, m_eop, m_rdy;
  logic [DW-1:0] m_data;
  logic [1:0]    m_port;
`ifdef PKT_ARB4_STAT_EN
  logic [4*CW-1:0] pkt_cnt;
`endif

  pkt_arb4 #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clks   (clks),
    .reset  (reset),
    .s_vld  (s_vld),
    .s_eop  (s_eop),
    .s_data (s_data),
    .s_rdy  (s_rdy),
    .m_vld  (m_vld),
    .m_eop  (m_eop),
    .m_data (m_data),
    .m_port (m_port),
    .m_rdy  (m_rdy)
`ifdef PKT_ARB4_STAT_EN
    ,
    .pkt_cnt(pkt_cnt)
`endif
  );

  always #5 clks = ~clks;

  beat_t src_q [4][$];
  beat_t exp_q [4][$];
  int    obs_q [$];
  int    exp_o [$];

  int   checks = 0;
  int   errors = 0;
  bit   m_busy = 1'b0;
  int   m_own = 0;
  int   m_ptr = 3;
  int   m_cnt [4];
  bit   rand_mode = 1'b0;
  bit   rdy_force = 1'b1;
  logic [3:0] vld_mask = 4'hf;
  logic [3:0] acc = 4'h0;

  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  task automatic add_pkt(int p, int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {$urandom, $urandom};
      b.eop  = (i == len - 1);
      src_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
  endtask

  function automatic bit pending();
    bit r = m_busy;
    for (int p = 0; p < 4; p++) if (src_q[p].size() != 0) r = 1'b1;
    return r;
  endfunction

  task automatic wait_idle(int budget);
    int n = 0;
    while (pending() && n < budget) begin
      @(negedge clks); #1;
      n++;
    end
    chk("drain_timeout", {63'd0, pending()}, 64'd0);
    for (int p = 0; p < 4; p++) chk("exp_left", exp_q[p].size(), 0);
  endtask

  task automatic wait_left(int p, int left, int budget);
    int n = 0;
    while (src_q[p].size() > left && n < budget) begin
      @(negedge clks); #1;
      n++;
    end
    chk("wait_beat_timeout", {63'd0, n >= budget}, 64'd0);
  endtask

  task automatic check_order();
    chk("order_len", obs_q.size(), exp_o.size());
    for (int i = 0; i < exp_o.size() && i < obs_q.size(); i++) begin
      chk($sformatf("order[%0d]", i), obs_q[i], exp_o[i]);
    end
    obs_q.delete();
  endtask

  // Source driver: present queue heads, retire accepted beats.
  initial begin
    s_vld = '0; s_eop = '0; s_data = '0; m_rdy = 1'b1;
    forever begin
      @(negedge clks);
      for (int p = 0; p < 4; p++) begin
        if (acc[p] && src_q[p].size() != 0) void'(src_q[p].pop_front());
      end
      for (int p = 0; p < 4; p++) begin
        if (src_q[p].size() != 0) begin
          s_data[p*DW +: DW] = src_q[p][0].data;
          s_eop[p] = src_q[p][0].eop;
          s_vld[p] = vld_mask[p] &&
                     (!rand_mode || $urandom_range(0, 3) != 0);
        end else begin
          s_vld[p] = 1'b0;
          s_eop[p] = 1'b0;
        end
      end
      m_rdy = rand_mode ? ($urandom_range(0, 3) != 0) : rdy_force;
      #4 acc = s_vld & s_rdy;
    end
  end

  // Monitor: packet-level round-robin reference and scoreboard.
  initial begin
    logic [3:0] er;
    bit ev, fin, found;
    forever begin
      @(negedge clks); #4;
      if (reset) begin
        m_busy = 1'b0; m_own = 0; m_ptr = 3;
        for (int p = 0; p < 4; p++) m_cnt[p] = 0;
      end else begin
        ev = m_busy && s_vld[m_own];
        er = 4'h0;
        if (m_busy) er[m_own] = m_rdy;
        chk("m_vld", {63'd0, m_vld}, {63'd0, ev});
        chk("m_port", m_port, m_own);
        chk("s_rdy", s_rdy, er);
        if (ev) begin
          chk("exp_nonempty", {63'd0, exp_q[m_own].size() != 0}, 64'd1);
        end
        if (ev && exp_q[m_own].size() != 0) begin
          chk("m_data", m_data, exp_q[m_own][0].data);
          chk("m_eop", {63'd0, m_eop}, {63'd0, exp_q[m_own][0].eop});
        end
        if (ev && m_rdy && exp_q[m_own].size() != 0) begin
          fin = exp_q[m_own][0].eop;
          void'(exp_q[m_own].pop_front());
          if (fin) begin
            obs_q.push_back(int'(m_port));
            m_cnt[m_own]++;
            m_ptr = m_own;
            m_busy = 1'b0;
          end
        end else if (!m_busy && s_vld != 0) begin
          found = 1'b0;
          for (int k = 1; k <= 4; k++) begin
            if (!found && s_vld[(m_ptr + k) % 4]) begin
              m_own = (m_ptr + k) % 4;
              found = 1'b1;
            end
          end
          m_busy = 1'b1;
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clks);
    #4;
    chk("rst_m_vld", {63'd0, m_vld}, 64'd0);
    chk("rst_s_rdy", s_rdy, 4'h0);
    chk("rst_m_port", m_port, 2'd0);
`ifdef PKT_ARB4_STAT_EN
    chk("rst_cnt", pkt_cnt[63:0], 64'd0);
    chk("rst_cnt_hi", pkt_cnt[127:64], 64'd0);
`endif
    @(negedge clks); #1;
    reset = 1'b0;

    add_pkt(2, 3);
    wait_idle(50);
    exp_o = {2};
    check_order();

    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++) add_pkt(p, 1);
    wait_idle(100);
    exp_o = {3, 0, 1, 2, 3, 0, 1, 2};
    check_order();

    add_pkt(1, 4);
    wait_left(1, 2, 50);
    vld_mask[1] = 1'b0;
    add_pkt(3, 1);
    repeat (2) @(negedge clks);
    #1 vld_mask[1] = 1'b1;
    wait_idle(100);
    exp_o = {1, 3};
    check_order();

    add_pkt(0, 4);
    wait_left(0, 2, 50);
    rdy_force = 1'b0;
    repeat (5) @(negedge clks);
    #1 rdy_force = 1'b1;
    wait_idle(100);
    exp_o = {0};
    check_order();

    rand_mode = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clks); #1;
      for (int p = 0; p < 4; p++) begin
        if (src_q[p].size() < 3 && $urandom_range(0, 7) == 0)
          add_pkt(p, $urandom_range(1, 4));
      end
    end
    rand_mode = 1'b0;
    wait_idle(1000);
    obs_q.delete();
`ifdef PKT_ARB4_STAT_EN
    for (int p = 0; p < 4; p++)
      chk($sformatf("cnt_rand[%0d]", p), pkt_cnt[p*CW +: CW], m_cnt[p]);
`endif

    add_pkt(1, 3);
    wait_left(1, 2, 50);
    #1 reset = 1'b1;
    #2;
    chk("midrst_m_vld", {63'd0, m_vld}, 64'd0);
    chk("midrst_s_rdy", s_rdy, 4'h0);
    chk("midrst_m_port", m_port, 2'd0);
    add_pkt(0, 1);
    @(negedge clks);
    reset = 1'b0;
    wait_idle(100);
    exp_o = {0, 1};
    check_order();

`ifdef PKT_ARB4_STAT_EN
    @(negedge clks); #1 reset = 1'b1;
    @(negedge clks); #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) add_pkt(0, $urandom_range(1, 3));
    for (int i = 0; i < 2; i++) add_pkt(3, $urandom_range(1, 3));
    wait_idle(200);
    obs_q.delete();
    chk("cnt0", pkt_cnt[0*CW +: CW], 3);
    chk("cnt1", pkt_cnt[1*CW +: CW], 0);
    chk("cnt2", pkt_cnt[2*CW +: CW], 0);
    chk("cnt3", pkt_cnt[3*CW +: CW], 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
